// File: rtl/fpga_input_debounce.sv
// Purpose : synchronise and debounce board switches and the single-step button; emit edge pulses, step requests and a sample tick.
// Latency : 2-flop synchroniser, then a level change needs STABLE_SAMPLES agreeing tick samples (worst case 2 + STABLE_SAMPLES*TICK_CYCLES cycles).
// Backpress: none; free-running, every output is a level or a one-cycle pulse. Optional build macro: AUTOREPEAT_EN (hold-to-repeat step).
module fpga_input_debounce #(
    parameter int SW_WIDTH       = 8,
    parameter int TICK_CYCLES    = 1_000_000,
    parameter int STABLE_SAMPLES = 3,
    parameter int HOLD_TICKS     = 25,
    parameter int REPEAT_TICKS   = 5
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [SW_WIDTH-1:0] iSwitch,
    input  logic                iStepBtn,
    output logic [SW_WIDTH-1:0] oSwitch,
    output logic [SW_WIDTH-1:0] oSwRise,
    output logic [SW_WIDTH-1:0] oSwFall,
    output logic                oStep,
    output logic                oTick
);

    // The step button is debounced as one extra bit on top of the switches.
    localparam int NB     = SW_WIDTH + 1;
    localparam int BTN    = SW_WIDTH;
    localparam int HIST   = STABLE_SAMPLES - 1;
    localparam int CNT_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);

    // Step FSM encoding; kept as plain constants for compatibility with older tools.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
`ifdef AUTOREPEAT_EN
    localparam logic [1:0] ST_REPEAT  = 2'd2;
    localparam int RPT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] HOLD_LAST   = RPT_W'(HOLD_TICKS - 1);
    localparam logic [RPT_W-1:0] REPEAT_LAST = RPT_W'(REPEAT_TICKS - 1);
`endif

    logic [NB-1:0]    syncMeta;
    logic [NB-1:0]    syncOut;
    logic [CNT_W-1:0] tickCount;
    logic             tickNow;
    logic [NB-1:0]    sampleHist [HIST];   // index 0 holds the most recent stored sample
    logic [NB-1:0]    level;
    logic [NB-1:0]    winOnes;
    logic [NB-1:0]    winZeros;
    logic [NB-1:0]    riseSet;
    logic [NB-1:0]    fallSet;
    logic             btnRise;
    logic             btnFall;
    logic [1:0]       stepState;
`ifdef AUTOREPEAT_EN
    logic [RPT_W-1:0] rptCount;
`endif

    // Two-flop synchroniser for all asynchronous pins.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            syncMeta <= '0;
            syncOut  <= '0;
        end else begin
            syncMeta <= {iStepBtn, iSwitch};
            syncOut  <= syncMeta;
        end
    end

    // The sample edge is the clock edge on which the counter sits at its last value.
    assign tickNow = (tickCount == TICK_LAST);

    // Free-running tick counter; the registered tick appears together with the level updates it causes.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            tickCount <= '0;
            oTick     <= 1'b0;
        end else begin
            oTick <= tickNow;
            if (tickNow) begin
                tickCount <= '0;
            end else begin
                tickCount <= tickCount + 1'b1;
            end
        end
    end

    // Candidate window = stored samples plus the current synchronised value; decide level changes.
    always_comb begin
        winOnes  = syncOut;
        winZeros = ~syncOut;
        for (int i = 0; i < HIST; i++) begin
            winOnes  = winOnes  & sampleHist[i];
            winZeros = winZeros & ~sampleHist[i];
        end
        riseSet = {NB{tickNow}} & winOnes  & ~level;
        fallSet = {NB{tickNow}} & winZeros &  level;
    end

    // Sample history shifts only on ticks, so a disagreeing sample breaks the run until it ages out.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < HIST; i++) begin
                sampleHist[i] <= '0;
            end
        end else if (tickNow) begin
            sampleHist[0] <= syncOut;
            for (int i = 1; i < HIST; i++) begin
                sampleHist[i] <= sampleHist[i-1];
            end
        end
    end

    // Debounced levels and their one-cycle edge pulses; rise and fall are mutually exclusive per bit.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            level   <= '0;
            oSwRise <= '0;
            oSwFall <= '0;
        end else begin
            level   <= (level | riseSet) & ~fallSet;
            oSwRise <= riseSet[SW_WIDTH-1:0];
            oSwFall <= fallSet[SW_WIDTH-1:0];
        end
    end

    assign oSwitch = level[SW_WIDTH-1:0];
    assign btnRise = riseSet[BTN];
    assign btnFall = fallSet[BTN];

`ifdef AUTOREPEAT_EN
    // Step FSM with hold-to-repeat: one pulse on press, then after HOLD_TICKS, then every REPEAT_TICKS; release wins.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stepState <= ST_IDLE;
            rptCount  <= '0;
            oStep     <= 1'b0;
        end else begin
            oStep <= 1'b0;
            case (stepState)
                ST_IDLE: begin
                    rptCount <= '0;
                    if (btnRise) begin
                        stepState <= ST_PRESSED;
                        oStep     <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (btnFall) begin
                        stepState <= ST_IDLE;
                        rptCount  <= '0;
                    end else if (tickNow) begin
                        if (rptCount == HOLD_LAST) begin
                            stepState <= ST_REPEAT;
                            rptCount  <= '0;
                            oStep     <= 1'b1;
                        end else begin
                            rptCount <= rptCount + 1'b1;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (btnFall) begin
                        stepState <= ST_IDLE;
                        rptCount  <= '0;
                    end else if (tickNow) begin
                        if (rptCount == REPEAT_LAST) begin
                            rptCount <= '0;
                            oStep    <= 1'b1;
                        end else begin
                            rptCount <= rptCount + 1'b1;
                        end
                    end
                end
                default: begin
                    stepState <= ST_IDLE;
                    rptCount  <= '0;
                end
            endcase
        end
    end
`else
    // Two-state step FSM: exactly one pulse per debounced press, nothing on hold or release.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stepState <= ST_IDLE;
            oStep     <= 1'b0;
        end else begin
            oStep <= 1'b0;
            case (stepState)
                ST_IDLE: begin
                    if (btnRise) begin
                        stepState <= ST_PRESSED;
                        oStep     <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (btnFall) begin
                        stepState <= ST_IDLE;
                    end
                end
                default: stepState <= ST_IDLE;
            endcase
        end
    end
`endif

endmodule

// File: doc/fpga_input_debounce.md
Name: fpga_input_debounce

Overview:
- Input-side companion to the board top-level that drives LEDs and the digit display. Synchronises and debounces the raw slide switches and a single-step push button.
- Produces clean switch levels and one-cycle edge pulses for the core's switch input.
- Produces a one-cycle step request that the top-level uses to single-step the multicycle core.
- Sits between the FPGA pins and the multicycle core, clocked by the board clock.

Parameters:
- SW_WIDTH, 8, number of switch bits debounced.
- TICK_CYCLES, 1_000_000, board-clock cycles per sample tick (20 ms at 50 MHz); must be ≥2.
- STABLE_SAMPLES, 3, consecutive agreeing tick samples required to change a debounced level; range 2..8.
- HOLD_TICKS, 25, ticks the step button must be held before auto-repeat starts (AUTOREPEAT_EN only).
- REPEAT_TICKS, 5, ticks between auto-repeat step pulses (AUTOREPEAT_EN only).

Ports:
- iClk  input  1  board clock.
- iRst  input  1  asynchronous, active-high reset.
- iSwitch  input  SW_WIDTH  raw, asynchronous switch pins.
- iStepBtn  input  1  raw, asynchronous step button; 1 = pressed.
- oSwitch  output  SW_WIDTH  debounced switch levels.
- oSwRise  output  SW_WIDTH  one-cycle pulse per bit on a debounced 0→1 change.
- oSwFall  output  SW_WIDTH  one-cycle pulse per bit on a debounced 1→0 change.
- oStep  output  1  one-cycle step request.
- oTick  output  1  one-cycle sample tick, for use by other blocks.

Behaviour:
- Reset: all of the following go to 0 immediately on iRst: synchroniser flops, sample shift registers, tick counter, oSwitch, oSwRise, oSwFall, oStep, oTick. The step FSM goes to IDLE. Reset mid-operation discards all history.
- Synchroniser: every iSwitch bit and iStepBtn passes through two flops. "sync" below means the second-flop value.
- Tick counter:
  - Counts 0..TICK_CYCLES-1 and wraps to 0.
  - oTick = 1 for exactly the cycle in which count == TICK_CYCLES-1, as a registered output.
  - The first oTick occurs TICK_CYCLES cycles after reset deasserts.
  - No ticks are lost or merged.
- Per-bit debounce:
  - Each bit, including the step button, has a shift register of STABLE_SAMPLES-1 stored samples.
  - On a tick edge, the candidate window is {stored samples, current sync}.
  - If the window is all 1s and the level is 0: level becomes 1 and the rise pulse is set on that same edge.
  - If the window is all 0s and the level is 1: level becomes 0 and the fall pulse is set on that same edge.
  - In all cases, sync is shifted in at that edge.
  - Between ticks, levels and shift registers hold.
  - Pulses last exactly one cycle; rise and fall are never both set.
  - Any disagreeing sample restarts qualification.
  - Worst-case latency from a clean input change to oSwitch: 2 + STABLE_SAMPLES×TICK_CYCLES cycles.
  - Glitches shorter than one tick interval that are not sampled are invisible.
- Step FSM (uses the debounced button level btn):
  - IDLE: btn rising → PRESSED, with oStep = 1 for one cycle (same edge as the debounced rise).
  - PRESSED: btn falling → IDLE, with no pulse.
  - Holding in PRESSED emits no further pulses (without the optional feature).
  - At most one oStep per debounced press.
- Simultaneous events: a tick coinciding with the counter wrap is the normal case. Switch edge pulses for several bits may coincide, and may coincide with oStep.

Optional Feature:
- Macro: AUTOREPEAT_EN.
- When defined:
  - PRESSED counts ticks while btn = 1. Once HOLD_TICKS ticks have elapsed, the FSM enters REPEAT and emits oStep on that tick edge.
  - In REPEAT, it emits oStep every REPEAT_TICKS ticks thereafter.
  - btn falling in PRESSED or REPEAT → IDLE, the counter clears, and no pulse is emitted.
  - A release coinciding with a repeat tick takes priority: no pulse.
- When undefined: no hold/repeat counter or REPEAT state exists; behaviour is exactly the two-state FSM above.

Test Plan:
1. TICK_CYCLES=4, STABLE_SAMPLES=3. Hold iSwitch=8'h00 through reset, then set 8'h05 cleanly. Required: oSwitch=8'h05 at the third tick after sync, with oSwRise=8'h05 for exactly one cycle; oSwFall stays 0.
2. Bounce bit 0 as 1,0,1 on successive ticks, then hold 1. Required: oSwitch[0] rises only after 3 consecutive 1 samples, with exactly one oSwRise[0] pulse.
3. Press iStepBtn cleanly for 20 ticks, then release. Required: exactly one oStep pulse, on the debounced-rise edge; no pulse on release.
4. With AUTOREPEAT_EN, HOLD_TICKS=4, REPEAT_TICKS=2, hold the button for 10 ticks after debounce. Required:
   - oStep at press, then at press+4 ticks, +6, +8, +10 ticks.
   - Release stops pulses.
5. Assert iRst mid-qualification and while oSwitch=8'hFF. Required: all outputs 0 at once; after release, oSwitch re-qualifies from zero history (oSwRise=8'hFF after 3 ticks of all-ones).
6. Count cycles between oTick pulses over 10 ticks. Required: exactly TICK_CYCLES each; first tick TICK_CYCLES cycles after reset release.
